// File: rtl/demux_32bit_buf.sv
// ---------------------------------------------------------------------------
// demux_32bit_buf
//
// Buffered 1-to-2 demultiplexer for 32-bit datapath words. One valid/ready
// input stream is steered word by word to channel A (in_sel=1) or channel B
// (in_sel=0). Each channel owns a 2-entry FIFO so that the shared producer
// is decoupled from two consumers that can stall independently. Each
// channel also keeps a free-running routed-word counter for debug.
//
// Handshake semantics (all interfaces in this file):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. ready never depends on valid. Once valid is raised the sender
//   holds its payload stable and keeps valid high until the transfer.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   in_data   word to route
//   in_sel    destination: 1 -> channel A, 0 -> channel B
//   in_valid  in_data / in_sel are valid
//   in_ready  selected channel has room this cycle (combinational)
//   a_data    head word of FIFO A (registered)
//   a_valid   FIFO A non-empty
//   a_ready   consumer A takes the head word
//   b_data    head word of FIFO B (registered)
//   b_valid   FIFO B non-empty
//   b_ready   consumer B takes the head word
//   a_count   words pushed into A since reset, wraps at 2^CNT_W
//   b_count   words pushed into B since reset, wraps at 2^CNT_W
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// demux_32bit_buf_chan
//
// One 2-entry channel FIFO with routed-word counter. The FIFO controller is
// a small state machine whose state encoding is the occupancy itself, so the
// state register doubles as the occupancy count.
//
// Ports:
//   clk, rst_n  clock / synchronous active-low reset
//   push        accept push_data this cycle (caller guarantees room)
//   push_data   word to store
//   pop_ready   consumer takes the head word when valid
//   data        head word, mem[rd_ptr]
//   valid       FIFO non-empty
//   count       number of pushes since reset, wrapping
//   state       occupancy / FSM state (EMPTY=0, ONE=1, FULL=2) for debug
// ---------------------------------------------------------------------------
module demux_32bit_buf_chan #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop_ready,
  output logic [DW-1:0]    data,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e             state_q;
  occ_e             state_d;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [DW-1:0]    mem_q [2];
  logic [CNT_W-1:0] count_q;
  logic             pop;

  // Pop only when there is a head word to hand out.
  assign pop = valid && pop_ready;

  // Next-state logic. A push into FULL cannot occur: the caller masks push
  // with in_ready, and there is deliberately no pop-then-push bypass.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (push) state_d = ONE;
      end
      ONE: begin
        if (push && !pop)      state_d = FULL;
        else if (pop && !push) state_d = EMPTY;
        // push && pop: stays ONE, head moves to the new word
      end
      FULL: begin
        if (pop) state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Storage, pointers and counter. Memory is cleared on reset so that the
  // head word reads 0 until a word has been written to that slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
        count_q         <= count_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign valid = (state_q != EMPTY);
  assign data  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign state = state_q;

endmodule

module demux_32bit_buf #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [31:0]      b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  // The channel FIFO is built for exactly two entries; DEPTH only sets the
  // occupancy limit used by in_ready.
  localparam logic [1:0] DEPTH_L = DEPTH[1:0];

  logic [1:0] a_state;
  logic [1:0] b_state;
  logic       push_a;
  logic       push_b;

  // in_ready looks only at the selected channel, so a stalled channel never
  // blocks words headed for the other one.
  assign in_ready = in_sel ? (a_state < DEPTH_L) : (b_state < DEPTH_L);

  assign push_a = in_valid && in_ready &&  in_sel;
  assign push_b = in_valid && in_ready && !in_sel;

  demux_32bit_buf_chan #(
    .DW    (32),
    .CNT_W (CNT_W)
  ) u_chan_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a),
    .push_data (in_data),
    .pop_ready (a_ready),
    .data      (a_data),
    .valid     (a_valid),
    .count     (a_count),
    .state     (a_state)
  );

  demux_32bit_buf_chan #(
    .DW    (32),
    .CNT_W (CNT_W)
  ) u_chan_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b),
    .push_data (in_data),
    .pop_ready (b_ready),
    .data      (b_data),
    .valid     (b_valid),
    .count     (b_count),
    .state     (b_state)
  );

endmodule

// File: tb/tb_demux_32bit_buf.sv
// ---------------------------------------------------------------------------
// tb_demux_32bit_buf
//
// Directed bench for demux_32bit_buf. A table of per-cycle records drives
// the inputs, checks in_ready before the edge and the registered outputs
// after it. A hand-written sequence covers counter wrap and reset with a
// word buffered in channel B.
// ---------------------------------------------------------------------------
module tb_demux_32bit_buf;

  // ---- clock / reset ------------------------------------------------------
  logic        clk;
  logic        rst_n;
  logic [31:0] in_data;
  logic        in_sel;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] b_data;
  logic        b_valid;
  logic        b_ready;
  logic [15:0] a_count;
  logic [15:0] b_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  demux_32bit_buf #(
    .DEPTH (2),
    .CNT_W (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .b_data   (b_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .a_count  (a_count),
    .b_count  (b_count)
  );

  // ---- scoreboard ---------------------------------------------------------
  int          n_chk;
  int          n_fail;
  logic [31:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---- vector table -------------------------------------------------------
  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic        in_sel;
    logic [31:0] in_data;
    logic        a_ready;
    logic        b_ready;
    logic        chk_rdy;
    logic        exp_rdy;
    logic        exp_av;
    logic [31:0] exp_ad;
    logic        exp_bv;
    logic [31:0] exp_bd;
    logic [15:0] exp_ac;
    logic [15:0] exp_bc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic rn, input logic v, input logic s, input logic [31:0] d,
    input logic ar, input logic br, input logic cr, input logic er,
    input logic av, input logic [31:0] ad, input logic bv, input logic [31:0] bd,
    input logic [15:0] ac, input logic [15:0] bc);
    vec_t r;
    r.rst_n = rn;  r.in_valid = v; r.in_sel = s; r.in_data = d;
    r.a_ready = ar; r.b_ready = br; r.chk_rdy = cr; r.exp_rdy = er;
    r.exp_av = av; r.exp_ad = ad; r.exp_bv = bv; r.exp_bd = bd;
    r.exp_ac = ac; r.exp_bc = bc;
    return r;
  endfunction

  // ---- driver -------------------------------------------------------------
  task automatic drive(input logic rn, input logic v, input logic s,
                       input logic [31:0] d, input logic ar, input logic br);
    @(negedge clk);
    rst_n    = rn;
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    a_ready  = ar;
    b_ready  = br;
    #1;
  endtask

  task automatic apply(input vec_t t, input int idx);
    drive(t.rst_n, t.in_valid, t.in_sel, t.in_data, t.a_ready, t.b_ready);
    if (t.chk_rdy) chk($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(t.exp_rdy));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d a_valid", idx), 32'(a_valid), 32'(t.exp_av));
    chk($sformatf("v%0d a_data", idx),  a_data,        t.exp_ad);
    chk($sformatf("v%0d b_valid", idx), 32'(b_valid), 32'(t.exp_bv));
    chk($sformatf("v%0d b_data", idx),  b_data,        t.exp_bd);
    chk($sformatf("v%0d a_count", idx), 32'(a_count), 32'(t.exp_ac));
    chk($sformatf("v%0d b_count", idx), 32'(b_count), 32'(t.exp_bc));
  endtask

  // ---- test ---------------------------------------------------------------
  initial begin
    logic [31:0] exp_w;
    n_chk    = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    in_data  = '0;
    a_ready  = 1'b0;
    b_ready  = 1'b0;

    //              rn v  s  data          ar br cr er  av ad            bv bd            ac     bc
    // reset held 2 cycles with a valid word presented
    vecs[0]  = mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0,  0, 32'h0,        0, 32'h0,        16'd0, 16'd0);
    vecs[1]  = mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0,  0, 32'h0,        0, 32'h0,        16'd0, 16'd0);
    vecs[2]  = mk(1, 0, 1, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 32'h0,        16'd0, 16'd0);
    vecs[3]  = mk(1, 0, 0, 32'h0,        0, 0, 1, 1,  0, 32'h0,        0, 32'h0,        16'd0, 16'd0);
    // alternating routing, both consumers ready
    vecs[4]  = mk(1, 1, 1, 32'h11111111, 1, 1, 1, 1,  1, 32'h11111111, 0, 32'h0,        16'd1, 16'd0);
    vecs[5]  = mk(1, 1, 0, 32'h22222222, 1, 1, 1, 1,  0, 32'h0,        1, 32'h22222222, 16'd1, 16'd1);
    vecs[6]  = mk(1, 1, 1, 32'h33333333, 1, 1, 1, 1,  1, 32'h33333333, 0, 32'h0,        16'd2, 16'd1);
    vecs[7]  = mk(1, 0, 0, 32'h0,        1, 1, 1, 1,  0, 32'h11111111, 0, 32'h0,        16'd2, 16'd1);
    // fill A and stall, then drain in order
    vecs[8]  = mk(1, 1, 1, 32'hA0,       0, 1, 1, 1,  1, 32'hA0,       0, 32'h0,        16'd3, 16'd1);
    vecs[9]  = mk(1, 1, 1, 32'hA1,       0, 1, 1, 1,  1, 32'hA0,       0, 32'h0,        16'd4, 16'd1);
    vecs[10] = mk(1, 1, 1, 32'hA2,       0, 1, 1, 0,  1, 32'hA0,       0, 32'h0,        16'd4, 16'd1);
    vecs[11] = mk(1, 1, 1, 32'hA2,       0, 1, 1, 0,  1, 32'hA0,       0, 32'h0,        16'd4, 16'd1);
    // a_ready high while FULL: pop only, no bypass
    vecs[12] = mk(1, 1, 1, 32'hA2,       1, 1, 1, 0,  1, 32'hA1,       0, 32'h0,        16'd4, 16'd1);
    vecs[13] = mk(1, 1, 1, 32'hA2,       1, 1, 1, 1,  1, 32'hA2,       0, 32'h0,        16'd5, 16'd1);
    // A full, B still accepts
    vecs[14] = mk(1, 1, 1, 32'hA3,       0, 1, 1, 1,  1, 32'hA2,       0, 32'h0,        16'd6, 16'd1);
    vecs[15] = mk(1, 1, 0, 32'hB5,       0, 1, 1, 1,  1, 32'hA2,       1, 32'hB5,       16'd6, 16'd2);
    vecs[16] = mk(1, 0, 0, 32'h0,        1, 1, 1, 1,  1, 32'hA3,       0, 32'h22222222, 16'd6, 16'd2);
    vecs[17] = mk(1, 0, 0, 32'h0,        1, 1, 1, 1,  0, 32'hA2,       0, 32'h22222222, 16'd6, 16'd2);
    // simultaneous push/pop while A holds one word
    vecs[18] = mk(1, 1, 1, 32'hC0,       0, 1, 1, 1,  1, 32'hC0,       0, 32'h22222222, 16'd7, 16'd2);
    vecs[19] = mk(1, 1, 1, 32'hC1,       1, 1, 1, 1,  1, 32'hC1,       0, 32'h22222222, 16'd8, 16'd2);
    vecs[20] = mk(1, 0, 0, 32'h0,        1, 1, 1, 1,  0, 32'hC0,       0, 32'h22222222, 16'd8, 16'd2);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // ---- counter wrap on B, then reset with a word buffered ----
    drive(1'b0, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("wrap pre-reset b_count", 32'(b_count), 32'd0);
    chk("wrap pre-reset b_valid", 32'(b_valid), 32'd0);

    for (int i = 0; i < 65537; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i), 1'b1, 1'b1);
      if (in_ready !== 1'b1) chk($sformatf("wrap in_ready w%0d", i), 32'(in_ready), 32'd1);
      if (b_valid && b_ready) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
        if (b_data !== exp_w) chk($sformatf("wrap b_data w%0d", i), b_data, exp_w);
      end
      exp_q.push_back(32'(i));
      @(posedge clk);
      #1;
      if (i == 65534) chk("wrap b_count 0xFFFF", 32'(b_count), 32'h0000FFFF);
      if (i == 65535) chk("wrap b_count 0x0000", 32'(b_count), 32'h00000000);
    end
    chk("wrap b_count final", 32'(b_count), 32'h00000001);
    chk("wrap b_valid final", 32'(b_valid), 32'd1);
    exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
    chk("wrap b_data final", b_data, exp_w);
    chk("wrap b_data last word", b_data, 32'h00010000);

    // reset with one word in B; the handshake offered in this cycle is ignored
    drive(1'b0, 1'b1, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("midreset b_valid", 32'(b_valid), 32'd0);
    chk("midreset b_count", 32'(b_count), 32'd0);
    chk("midreset b_data",  b_data,       32'd0);
    chk("midreset a_count", 32'(a_count), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);

    // ---- report ----
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_32bit_buf.md
# demux_32bit_buf

Buffered 1-to-2 demultiplexer for 32-bit datapath words: a single valid/ready input stream is steered, word by word, to output channel A or B by a per-word select bit. It is the distributing counterpart of the 2:1 word selector in the datapath. It separates a shared producer, such as a writeback or load-return path, from two consumers that may stall independently. Each channel has a 2-entry FIFO and a 16-bit routed-word counter for debug.

## Interface
Parameters:
- DEPTH, 2, entries per channel FIFO; fixed at 2, not to be overridden.
- CNT_W, 16, width of the per-channel routed-word counters.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_data  input  32  word to route.
- in_sel  input  1  destination select: 1 routes to channel A, 0 routes to channel B (same polarity as the 2:1 selector).
- in_valid  input  1  in_data and in_sel are valid.
- in_ready  output  1  the selected channel can accept a word this cycle.
- a_data  output  32  head word of FIFO A.
- a_valid  output  1  FIFO A is non-empty.
- a_ready  input  1  consumer A takes the head word.
- b_data  output  32  head word of FIFO B.
- b_valid  output  1  FIFO B is non-empty.
- b_ready  input  1  consumer B takes the head word.
- a_count  output  CNT_W  number of words pushed into A since reset, mod 2^16.
- b_count  output  CNT_W  number of words pushed into B since reset, mod 2^16.

## Operation
- Handshake rules
  - An input transfer occurs when in_valid and in_ready are both high on a rising edge.
  - An output transfer occurs when x_valid and x_ready are both high on a rising edge.
  - in_ready = (in_sel ? occA : occB) < 2. It depends only on in_sel and the occupancy of the selected FIFO, never on in_valid.
  - The producer holds in_data and in_sel stable while in_valid is high and in_ready is low.
  - The producer must not lower in_valid before the transfer completes.
- FIFO structure
  - Each channel has 2 entries, a 1-bit write pointer, a 1-bit read pointer, and a 2-bit occupancy count (0..2).
  - Pointers wrap from 1 to 0.
- Per-channel state machine, encoded by occupancy: EMPTY(0), ONE(1), FULL(2).
  - EMPTY: push goes to ONE.
  - ONE: push without pop goes to FULL. Pop without push goes to EMPTY. Push and pop together stay in ONE, with the head advancing to the newly pushed word.
  - FULL: pop goes to ONE. No push is possible because in_ready is low for this channel.
  - There is no same-cycle bypass: a push into a FULL FIFO is not accepted, even if x_ready is high in that cycle.
- Outputs
  - x_valid = (occ != 0).
  - x_data = mem[rd_ptr]. It is 0 while the FIFO has never been written since reset; after that it holds stale data when empty.
- Counters
  - a_count increments on every push into A, and b_count on every push into B.
  - Counters wrap from 0xFFFF to 0x0000.
  - Pops do not affect the counters.
- Independence
  - A stall on one channel never blocks words selected for the other channel.
  - Words within a channel leave in the order they were accepted.

## Timing
- Reset
  - While rst_n is low at a rising edge: occupancies, pointers, a_count and b_count go to 0, and memory contents are cleared to 0.
  - After that edge: a_valid = b_valid = 0, a_data = b_data = 0, and in_ready = 1 for either value of in_sel.
  - Reset asserted mid-stream discards all buffered words. Handshakes seen in the reset cycle have no effect.
- Latency
  - A word accepted at edge N appears on x_data with x_valid high after edge N, which is 1 cycle of latency.
  - If x_ready is high in that next cycle, the word leaves at edge N+1.
- Throughput: 1 word per cycle per channel is sustained when the consumer holds x_ready high.
- All outputs are driven from registers, except in_ready, which is a combinational function of in_sel and the registered occupancies.

## Test plan
- Reset check
  - Stimulus: hold rst_n=0 for 2 cycles with in_valid=1, in_data=0xDEADBEEF.
  - Required response: after release, a_valid=b_valid=0, a_count=b_count=0, a_data=b_data=0, in_ready=1.
- Alternating routing
  - Stimulus: with a_ready=b_ready=1, send 0x11111111 (sel=1), 0x22222222 (sel=0), 0x33333333 (sel=1) on consecutive cycles.
  - Required response: A outputs 0x11111111 then 0x33333333, B outputs 0x22222222, each 1 cycle after acceptance; a_count=2, b_count=1.
- Fill and stall
  - Stimulus: a_ready=0, send 0xA0, 0xA1, 0xA2 all with sel=1.
  - Required response: in_ready drops after 2 words and 0xA2 is held. Raise a_ready: 0xA0 and 0xA1 drain in order, then 0xA2 is accepted and appears.
- Independence
  - Stimulus: A held full with a_ready=0; present 0xB5 with sel=0 and b_ready=1.
  - Required response: in_ready=1, and b_data=0xB5 with b_valid high the next cycle.
- Simultaneous push/pop in ONE
  - Stimulus: A holds 0xC0; in the same cycle, pop with a_ready=1 and push 0xC1.
  - Required response: occupancy stays 1 and a_data=0xC1 the next cycle.
- Wrap and reset mid-operation
  - Stimulus: push 65537 words into B.
  - Required response: b_count=0x0001 after the final push.
  - Stimulus: then assert rst_n=0 with B holding 1 word.
  - Required response: b_valid=0 and b_count=0 after the reset edge.
